// File: rtl/tank_access_sched_pkg.sv
// Shared constants, FSM encoding and arbitration helper for the tank access scheduler.
package tank_access_sched_pkg;

   localparam int DEF_POS_W       = 5;
   localparam int DEF_WORD_DIGITS = 18;
   localparam int DEF_TMO_HMC     = 34;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_ARMED = 3'd2,
      S_XFER  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Returns 1 when the operand requester wins; ties go to whoever did not win last.
   function automatic logic pick_o(input logic req_f, input logic req_o, input logic last_o);
      if (req_f && req_o) begin
         return !last_o;
      end
      return req_o;
   endfunction

endpackage

// File: rtl/tank_access_sched_coincidence.sv
// Digit index tracker, serial position deserialiser and word-position compare.
// coin is high for the one clock in which digit POS_W-1 has just been captured and pos matches addr.
module tank_coincidence #(
   parameter int POS_W       = 5,
   parameter int WORD_DIGITS = 18,
   parameter int DIG_W       = $clog2(WORD_DIGITS)
) (
   input  logic             clk,
   input  logic             reset_neg,
   input  logic             d0,
   input  logic             cntr,
   input  logic [POS_W-1:0] addr,
   output logic [DIG_W-1:0] digit,
   output logic             coin
);

   logic [DIG_W-1:0] dig_reg;
   logic [DIG_W-1:0] dig_next;
   logic [POS_W-1:0] pos_reg;

   // dig_next is the digit of the clock being sampled; d0 always resynchronises it.
   always_comb begin
      dig_next = dig_reg;
      if (d0) begin
         dig_next = '0;
      end else if (dig_reg != DIG_W'(WORD_DIGITS - 1)) begin
         dig_next = dig_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_neg) begin
      if (!reset_neg) begin
         dig_reg <= '0;
      end else begin
         dig_reg <= dig_next;
      end
   end

   generate
      for (genvar gi = 0; gi < POS_W; gi++) begin : g_pos_bit
         always_ff @(posedge clk or negedge reset_neg) begin
            if (!reset_neg) begin
               pos_reg[gi] <= 1'b0;
            end else if (dig_next == DIG_W'(gi)) begin
               pos_reg[gi] <= cntr;
            end
         end
      end
   endgenerate

   assign digit = dig_reg;
   assign coin  = (dig_reg == DIG_W'(POS_W - 1)) && (pos_reg == addr);

endmodule

// File: rtl/tank_access_sched.sv
// Arbitrates fetch and operand access to one recirculating tank and opens the
// read or write gate for exactly the requested word time.
module tank_access_sched
   import tank_access_sched_pkg::*;
#(
   parameter int POS_W       = DEF_POS_W,
   parameter int WORD_DIGITS = DEF_WORD_DIGITS,
   parameter int TMO_HMC     = DEF_TMO_HMC
) (
   input  logic             clk,
   input  logic             reset_neg,
   input  logic             d0,
   input  logic             cntr,
   input  logic             req_f,
   input  logic [POS_W-1:0] addr_f,
   input  logic             req_o,
   input  logic [POS_W-1:0] addr_o,
   input  logic             wr_o,
   output logic             rd_gate,
   output logic             wr_gate,
   output logic             grant_o,
   output logic             busy,
   output logic             ack_f,
   output logic             ack_o,
   output logic             err_tmo
);

   localparam int DIG_W = $clog2(WORD_DIGITS);
   localparam int HMC_W = $clog2(TMO_HMC);

   state_t           state_reg;
   state_t           state_next;
   logic             winner_reg;
   logic             last_grant_reg;
   logic [POS_W-1:0] addr_reg;
   logic             wr_reg;
   logic             tmo_reg;
   logic [HMC_W-1:0] hmc_reg;

   logic [DIG_W-1:0] digit;
   logic             coin;
   logic             win_next;
   logic             last_digit;
   logic             hmc_expired;

   tank_coincidence #(
      .POS_W       (POS_W),
      .WORD_DIGITS (WORD_DIGITS),
      .DIG_W       (DIG_W)
   ) u_coin (
      .clk       (clk),
      .reset_neg (reset_neg),
      .d0        (d0),
      .cntr      (cntr),
      .addr      (addr_reg),
      .digit     (digit),
      .coin      (coin)
   );

   assign win_next    = pick_o(req_f, req_o, last_grant_reg);
   assign last_digit  = (digit == DIG_W'(WORD_DIGITS - 1));
   assign hmc_expired = d0 && (hmc_reg == HMC_W'(TMO_HMC - 1));

   always_ff @(posedge clk or negedge reset_neg) begin
      if (!reset_neg) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // The window closes on the clock after digit WORD_DIGITS-1; any earlier d0 aborts it.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (req_f || req_o) state_next = S_WAIT;
         S_WAIT: begin
            if (coin) begin
               state_next = S_ARMED;
            end else if (hmc_expired) begin
               state_next = S_DONE;
            end
         end
         S_ARMED: if (d0) state_next = S_XFER;
         S_XFER:  if (last_digit || d0) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_neg) begin
      if (!reset_neg) begin
         winner_reg     <= 1'b0;
         last_grant_reg <= 1'b1;
         addr_reg       <= '0;
         wr_reg         <= 1'b0;
         tmo_reg        <= 1'b0;
         hmc_reg        <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (req_f || req_o) begin
                  winner_reg <= win_next;
                  addr_reg   <= win_next ? addr_o : addr_f;
                  wr_reg     <= win_next & wr_o;
                  tmo_reg    <= 1'b0;
                  hmc_reg    <= '0;
               end
            end
            S_WAIT: begin
               if (!coin && d0) begin
                  hmc_reg <= hmc_reg + 1'b1;
                  if (hmc_expired) begin
                     tmo_reg <= 1'b1;
                  end
               end
            end
            S_XFER: begin
               if (d0 && !last_digit) begin
                  tmo_reg <= 1'b1;
               end
            end
            S_DONE: last_grant_reg <= winner_reg;
            default: ;
         endcase
      end
   end

   // Every output decodes registered state only, so nothing passes straight from the inputs.
   always_comb begin
      rd_gate = 1'b0;
      wr_gate = 1'b0;
      ack_f   = 1'b0;
      ack_o   = 1'b0;
      err_tmo = 1'b0;
      busy    = (state_reg != S_IDLE);
      grant_o = winner_reg;
      if (state_reg == S_XFER) begin
         rd_gate = !wr_reg;
         wr_gate = wr_reg;
      end
      if (state_reg == S_DONE) begin
         ack_f   = !winner_reg;
         ack_o   = winner_reg;
         err_tmo = tmo_reg;
      end
   end

endmodule

// File: tb/tb_tank_access_sched.sv
// Directed bench for tank_access_sched: table of single/dual request transactions
// plus hand-written timeout, async-reset and early-d0 sequences.
module tb_tank_access_sched;

   localparam int WD = 18;

   logic       clk = 1'b0;
   logic       reset_neg = 1'b0;
   logic       d0 = 1'b0;
   logic       cntr = 1'b0;
   logic       req_f = 1'b0;
   logic [4:0] addr_f = '0;
   logic       req_o = 1'b0;
   logic [4:0] addr_o = '0;
   logic       wr_o = 1'b0;
   logic       rd_gate, wr_gate, grant_o, busy, ack_f, ack_o, err_tmo;

   tank_access_sched dut (
      .clk       (clk),
      .reset_neg (reset_neg),
      .d0        (d0),
      .cntr      (cntr),
      .req_f     (req_f),
      .addr_f    (addr_f),
      .req_o     (req_o),
      .addr_o    (addr_o),
      .wr_o      (wr_o),
      .rd_gate   (rd_gate),
      .wr_gate   (wr_gate),
      .grant_o   (grant_o),
      .busy      (busy),
      .ack_f     (ack_f),
      .ack_o     (ack_o),
      .err_tmo   (err_tmo)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // stream and monitor state
   int   tb_pos = 0;
   int   cur_pos = 0;
   logic cntr_zero = 1'b0;
   int   cyc = 0;
   int   rd_cnt, wr_cnt, nf, no, nerr, err_alone, overlap;
   int   rise_pos, first_ack, ack_cyc, fall_cyc, d0_busy, d0_at_ack;
   logic rise_grant, gate_prev;

   typedef struct {
      logic       rf;
      logic       ro;
      logic [4:0] af;
      logic [4:0] ao;
      logic       wo;
      int         start;
      int         e_rise;
      logic       e_grant;
      int         e_rd;
      int         e_wr;
      int         e_nf;
      int         e_no;
      int         e_first_o;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      rd_cnt = 0; wr_cnt = 0; nf = 0; no = 0; nerr = 0; err_alone = 0; overlap = 0;
      rise_pos = -1; first_ack = -1; ack_cyc = -100; fall_cyc = -200;
      d0_busy = 0; d0_at_ack = -1; rise_grant = 1'b0; gate_prev = 1'b0;
   endtask

   task automatic tick();
      logic busy_pre;
      logic gate;
      busy_pre = busy;
      @(posedge clk);
      #1;
      cyc++;
      if (d0 && busy_pre) d0_busy++;
      if (rd_gate && wr_gate) overlap++;
      rd_cnt += int'(rd_gate);
      wr_cnt += int'(wr_gate);
      gate = rd_gate | wr_gate;
      if (gate && !gate_prev && rise_pos < 0) begin
         rise_pos   = cur_pos;
         rise_grant = grant_o;
      end
      if (!gate && gate_prev) fall_cyc = cyc;
      if (ack_f || ack_o) begin
         if (first_ack < 0) first_ack = int'(ack_o);
         ack_cyc   = cyc;
         d0_at_ack = d0_busy;
         if (ack_f) begin nf++; req_f = 1'b0; end
         if (ack_o) begin no++; req_o = 1'b0; end
         if (err_tmo) nerr++;
      end else if (err_tmo) begin
         err_alone++;
      end
      gate_prev = gate;
   endtask

   // One half minor cycle of the position stream; optional extra d0 or reset at a given digit.
   task automatic do_hmc(input int abort_dig, input int rst_dig);
      logic [4:0] pos_v;
      pos_v = 5'(tb_pos);
      for (int k = 0; k < WD; k++) begin
         cur_pos = tb_pos;
         d0 = (k == 0) || (k == abort_dig);
         if (cntr_zero) cntr = 1'b0;
         else if (k < 5) cntr = pos_v[k];
         else cntr = 1'($urandom_range(0, 1));
         if (k == rst_dig) begin
            check("gate_before_rst", rd_gate, 1);
            #2 reset_neg = 1'b0;
            #1;
            check("outs_in_rst", {rd_gate, wr_gate, grant_o, busy, ack_f, ack_o, err_tmo}, 0);
            rd_cnt = 0;
            gate_prev = 1'b0;
         end
         tick();
      end
      tb_pos = (tb_pos + 1) % 32;
      if (rst_dig >= 0) reset_neg = 1'b1;
   endtask

   task automatic run_until_done(input int budget);
      int n;
      n = 0;
      while ((req_f || req_o) && n < budget) begin
         do_hmc(-1, -1);
         n++;
      end
      check("done_in_budget", int'(req_f | req_o), 0);
   endtask

   task automatic do_reset();
      reset_neg = 1'b0;
      d0 = 1'b0; cntr = 1'b0; req_f = 1'b0; req_o = 1'b0; wr_o = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_neg = 1'b1;
      clear_mon();
   endtask

   initial begin
      tbl[0] = '{rf:1, ro:1, af:10, ao:12, wo:0, start:8,  e_rise:11, e_grant:0, e_rd:36, e_wr:0,  e_nf:1, e_no:1, e_first_o:0};
      tbl[1] = '{rf:1, ro:0, af:5,  ao:0,  wo:0, start:3,  e_rise:6,  e_grant:0, e_rd:18, e_wr:0,  e_nf:1, e_no:0, e_first_o:0};
      tbl[2] = '{rf:0, ro:1, af:0,  ao:31, wo:1, start:29, e_rise:0,  e_grant:1, e_rd:0,  e_wr:18, e_nf:0, e_no:1, e_first_o:1};
      tbl[3] = '{rf:0, ro:1, af:0,  ao:0,  wo:0, start:30, e_rise:1,  e_grant:1, e_rd:18, e_wr:0,  e_nf:0, e_no:1, e_first_o:1};
      tbl[4] = '{rf:1, ro:1, af:20, ao:20, wo:1, start:19, e_rise:21, e_grant:0, e_rd:18, e_wr:18, e_nf:1, e_no:1, e_first_o:0};

      for (int i = 0; i < 5; i++) begin
         do_reset();
         check("reset_outs", {rd_gate, wr_gate, grant_o, busy, ack_f, ack_o, err_tmo}, 0);
         tb_pos = tbl[i].start;
         addr_f = tbl[i].af; addr_o = tbl[i].ao; wr_o = tbl[i].wo;
         req_f = tbl[i].rf; req_o = tbl[i].ro;
         run_until_done(80);
         check("rise_pos",  rise_pos, tbl[i].e_rise);
         check("rise_grant", rise_grant, tbl[i].e_grant);
         check("rd_cycles", rd_cnt, tbl[i].e_rd);
         check("wr_cycles", wr_cnt, tbl[i].e_wr);
         check("ack_f_cnt", nf, tbl[i].e_nf);
         check("ack_o_cnt", no, tbl[i].e_no);
         check("first_ack_o", first_ack, tbl[i].e_first_o);
         check("err_cnt", nerr + err_alone, 0);
         check("ack_after_window", ack_cyc - fall_cyc, 0);
         check("gate_overlap", overlap, 0);
         $display("vector %0d: rise_pos=%0d rd=%0d wr=%0d ack_f=%0d ack_o=%0d", i, rise_pos, rd_cnt, wr_cnt, nf, no);
      end

      // timeout: position never matches
      do_reset();
      cntr_zero = 1'b1;
      tb_pos = 0; addr_f = 5'd7; req_f = 1'b1;
      run_until_done(40);
      cntr_zero = 1'b0;
      check("tmo_d0_count", d0_at_ack, 34);
      check("tmo_err", nerr, 1);
      check("tmo_ack_f", nf, 1);
      check("tmo_no_gate", rd_cnt + wr_cnt, 0);
      check("tmo_busy_after", busy, 0);
      $display("timeout: d0 seen=%0d err=%0d", d0_at_ack, nerr);

      // async reset at digit 9 of the window, then a normal re-request
      do_reset();
      tb_pos = 3; addr_f = 5'd4; req_f = 1'b1;
      do_hmc(-1, -1);
      do_hmc(-1, -1);
      do_hmc(-1, 9);
      check("rst_no_ack", nf + nerr + err_alone, 0);
      run_until_done(40);
      check("rst_reserve_ack", nf, 1);
      check("rst_reserve_rd", rd_cnt, 18);
      check("rst_reserve_err", nerr, 0);
      $display("async reset: re-request rd=%0d ack_f=%0d", rd_cnt, nf);

      // early d0 at digit 12 of the window
      do_reset();
      tb_pos = 3; addr_f = 5'd4; req_f = 1'b1;
      do_hmc(-1, -1);
      do_hmc(-1, -1);
      do_hmc(12, -1);
      run_until_done(4);
      check("abort_rise_pos", rise_pos, 5);
      check("abort_rd", rd_cnt, 12);
      check("abort_err", nerr, 1);
      check("abort_ack_f", nf, 1);
      check("abort_ack_timing", ack_cyc - fall_cyc, 0);
      $display("early d0: rd=%0d err=%0d", rd_cnt, nerr);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
